// File: rtl/lut_rd_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lut_rd_iter_ctrl
// Brief    : Read-side iteration sequencer for decomposed-LUT decoding. Drives
//            the CNU/VNU write-update handshake (iteration-update level,
//            read-finish flag, initial-load enable), steps RD_CYCLES LUT layer
//            reads per iteration for ITER_MAX iterations, then pulses done.
// Options  : LUT_RD_ACK_TIMEOUT_EN - adds an acknowledge watchdog that moves
//            the sequencer to a sticky ERR state after TIMEOUT_CYC cycles of
//            waiting in INIT, INIT_REL, RD_DONE or WR_REL.
// Revision : 1.0 - initial release
// ============================================================================
module lut_rd_iter_ctrl #(
  parameter int ITER_MAX    = 10,
  parameter int ITER_W      = 4,
  parameter int RD_CYCLES   = 8,
  parameter int RD_W        = 3,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              read_clk,
  input  logic              rstn,
  input  logic              start_i,
  input  logic              wr_ack_i,
  input  logic              init_load_i,
  input  logic              pipe_load_i,
  output logic              iter_update_o,
  output logic              rd_finish_o,
  output logic              init_load_en_o,
  output logic              rd_en_o,
  output logic [RD_W-1:0]   rd_addr_o,
  output logic [ITER_W-1:0] iter_cnt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  // Last read layer and last iteration index, sized to their counters.
  localparam logic [RD_W-1:0]   c_RD_LAST   = RD_W'(RD_CYCLES - 1);
  localparam logic [ITER_W-1:0] c_ITER_LAST = ITER_W'(ITER_MAX - 1);

`ifdef LUT_RD_ACK_TIMEOUT_EN
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INIT     = 4'd1,
    S_INIT_REL = 4'd2,
    S_READ     = 4'd3,
    S_RD_DONE  = 4'd4,
    S_WR_REL   = 4'd5,
    S_NEXT     = 4'd6,
    S_DONE     = 4'd7,
    S_ERR      = 4'd8
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INIT     = 4'd1,
    S_INIT_REL = 4'd2,
    S_READ     = 4'd3,
    S_RD_DONE  = 4'd4,
    S_WR_REL   = 4'd5,
    S_NEXT     = 4'd6,
    S_DONE     = 4'd7
  } state_t;
`endif

  state_t            r_state;
  logic              r_iter_update;
  logic              r_rd_finish;
  logic              r_init_load_en;
  logic              r_rd_en;
  logic [RD_W-1:0]   r_rd_addr;
  logic [ITER_W-1:0] r_iter_cnt;
  logic              r_busy;
  logic              r_done;

  // The load strobes carry status only; they never steer the sequencer.
  logic w_unused_status;
  assign w_unused_status = init_load_i | pipe_load_i;

`ifdef LUT_RD_ACK_TIMEOUT_EN
  localparam int               c_TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

  logic              r_err;
  logic [c_TO_W-1:0] r_wait;
  logic              w_wait_hold;
  logic              w_timeout;

  // The sequencer stays put this cycle in one of the acknowledge-wait states.
  always_comb begin
    w_wait_hold = 1'b0;
    case (r_state)
      S_INIT:     w_wait_hold = !wr_ack_i;
      S_INIT_REL: w_wait_hold =  wr_ack_i;
      S_RD_DONE:  w_wait_hold = !wr_ack_i;
      S_WR_REL:   w_wait_hold =  wr_ack_i;
      default:    w_wait_hold = 1'b0;
    endcase
    w_timeout = w_wait_hold && (r_wait == c_TO_LAST);
  end

  // Watchdog: counts cycles spent in the current wait state, zero on any move.
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      r_wait <= '0;
    end else if (w_wait_hold && !w_timeout) begin
      r_wait <= r_wait + c_TO_W'(1);
    end else begin
      r_wait <= '0;
    end
  end

  assign err_o = r_err;
`else
  localparam int c_UNUSED_TIMEOUT = TIMEOUT_CYC;
  assign err_o = 1'b0;
`endif

  // Sequencer FSM with all handshake and read-port outputs registered.
  always_ff @(posedge read_clk or negedge rstn) begin
    if (!rstn) begin
      r_state        <= S_IDLE;
      r_iter_update  <= 1'b0;
      r_rd_finish    <= 1'b0;
      r_init_load_en <= 1'b0;
      r_rd_en        <= 1'b0;
      r_rd_addr      <= '0;
      r_iter_cnt     <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
`ifdef LUT_RD_ACK_TIMEOUT_EN
      r_err          <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start_i) begin
            r_state        <= S_INIT;
            r_init_load_en <= 1'b1;
            r_busy         <= 1'b1;
            r_iter_cnt     <= '0;
            r_rd_addr      <= '0;
          end
        end

        // Initial load requested; first ack rising edge releases it.
        S_INIT: begin
          if (wr_ack_i) begin
            r_state        <= S_INIT_REL;
            r_init_load_en <= 1'b0;
          end
        end

        // Wait for the ack to fall before the first read pass.
        S_INIT_REL: begin
          if (!wr_ack_i) begin
            r_state   <= S_READ;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
          end
        end

        // One LUT layer per cycle; the ack is deliberately ignored here.
        S_READ: begin
          if (r_rd_addr == c_RD_LAST) begin
            r_state     <= S_RD_DONE;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_finish <= 1'b1;
          end else begin
            r_rd_addr <= r_rd_addr + RD_W'(1);
          end
        end

        // Read phase finished; hold the flag until the writer acknowledges.
        S_RD_DONE: begin
          if (wr_ack_i) begin
            r_state     <= S_WR_REL;
            r_rd_finish <= 1'b0;
          end
        end

        S_WR_REL: begin
          if (!wr_ack_i) begin
            r_state <= S_NEXT;
          end
        end

        // Iteration boundary: flip the update level, advance or finish.
        S_NEXT: begin
          r_iter_update <= ~r_iter_update;
          if (r_iter_cnt == c_ITER_LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_READ;
            r_iter_cnt <= r_iter_cnt + ITER_W'(1);
            r_rd_en    <= 1'b1;
            r_rd_addr  <= '0;
          end
        end

        // done_o is high for exactly this state; iter_cnt_o keeps its value.
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

`ifdef LUT_RD_ACK_TIMEOUT_EN
        // Stuck handshake: only a fresh start request recovers.
        S_ERR: begin
          if (start_i) begin
            r_state        <= S_INIT;
            r_err          <= 1'b0;
            r_init_load_en <= 1'b1;
            r_iter_cnt     <= '0;
            r_rd_addr      <= '0;
          end
        end
`endif

        default: begin
          r_state        <= S_IDLE;
          r_rd_finish    <= 1'b0;
          r_init_load_en <= 1'b0;
          r_rd_en        <= 1'b0;
          r_busy         <= 1'b0;
          r_done         <= 1'b0;
        end
      endcase

`ifdef LUT_RD_ACK_TIMEOUT_EN
      // A timeout only occurs in a holding wait state, so this override never
      // collides with a legal transition taken above.
      if (w_timeout) begin
        r_state        <= S_ERR;
        r_init_load_en <= 1'b0;
        r_rd_en        <= 1'b0;
        r_rd_finish    <= 1'b0;
        r_done         <= 1'b0;
        r_busy         <= 1'b1;
        r_err          <= 1'b1;
      end
`endif
    end
  end

  assign iter_update_o  = r_iter_update;
  assign rd_finish_o    = r_rd_finish;
  assign init_load_en_o = r_init_load_en;
  assign rd_en_o        = r_rd_en;
  assign rd_addr_o      = r_rd_addr;
  assign iter_cnt_o     = r_iter_cnt;
  assign busy_o         = r_busy;
  assign done_o         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_lut_rd_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_rd_iter_ctrl
// Brief    : Directed bench for lut_rd_iter_ctrl. Instance A uses ITER_MAX=3,
//            RD_CYCLES=4; instance B uses ITER_MAX=1, RD_CYCLES=1.
//            Timeout scenario is built only with LUT_RD_ACK_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_rd_iter_ctrl;

  logic read_clk = 1'b0;
  logic rstn     = 1'b0;

  always #5 read_clk = ~read_clk;

  // Instance A stimulus/observation
  logic       start_a = 1'b0, ack_a = 1'b0, init_load_a = 1'b0, pipe_load_a = 1'b0;
  logic       iu_a, fin_a, ile_a, rden_a, busy_a, done_a, err_a;
  logic [2:0] addr_a;
  logic [3:0] iter_a;

  // Instance B stimulus/observation
  logic       start_b = 1'b0, ack_b = 1'b0;
  logic       iu_b, fin_b, ile_b, rden_b, busy_b, done_b, err_b;
  logic [0:0] addr_b;
  logic [0:0] iter_b;

  lut_rd_iter_ctrl #(
    .ITER_MAX(3), .ITER_W(4), .RD_CYCLES(4), .RD_W(3), .TIMEOUT_CYC(64)
  ) u_dut_a (
    .read_clk(read_clk), .rstn(rstn), .start_i(start_a), .wr_ack_i(ack_a),
    .init_load_i(init_load_a), .pipe_load_i(pipe_load_a),
    .iter_update_o(iu_a), .rd_finish_o(fin_a), .init_load_en_o(ile_a),
    .rd_en_o(rden_a), .rd_addr_o(addr_a), .iter_cnt_o(iter_a),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
  );

  lut_rd_iter_ctrl #(
    .ITER_MAX(1), .ITER_W(1), .RD_CYCLES(1), .RD_W(1), .TIMEOUT_CYC(64)
  ) u_dut_b (
    .read_clk(read_clk), .rstn(rstn), .start_i(start_b), .wr_ack_i(ack_b),
    .init_load_i(1'b0), .pipe_load_i(1'b0),
    .iter_update_o(iu_b), .rd_finish_o(fin_b), .init_load_en_o(ile_b),
    .rd_en_o(rden_b), .rd_addr_o(addr_b), .iter_cnt_o(iter_b),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Run bookkeeping for instance A
  int   n_rd, n_tog, n_done, ncyc, first_rd, wcnt, inject_at, dly_rd, pipe_bad;
  int   addr_log [0:63];
  int   iter_log [0:63];
  logic prev_iu;
  bit   resp_en;

  task automatic do_reset();
    start_a = 0; ack_a = 0; pipe_load_a = 0; init_load_a = 0;
    start_b = 0; ack_b = 0;
    rstn = 0;
    repeat (2) @(negedge read_clk);
    rstn = 1;
    @(negedge read_clk);
  endtask

  task automatic clear_stats();
    n_rd = 0; n_tog = 0; n_done = 0; ncyc = 0; first_rd = -1; wcnt = 0;
    inject_at = -1; dly_rd = 2; pipe_bad = 0; resp_en = 1;
    prev_iu = iu_a;
    for (int i = 0; i < 64; i++) begin
      addr_log[i] = -1;
      iter_log[i] = -1;
    end
  endtask

  // One cycle on instance A: record outputs, then act as the handshake block.
  task automatic cycle_a();
    @(negedge read_clk);
    ncyc++;
    if (rden_a) begin
      if (n_rd < 64) begin
        addr_log[n_rd] = int'(addr_a);
        iter_log[n_rd] = int'(iter_a);
      end
      n_rd++;
      if (first_rd < 0) first_rd = ncyc;
    end
    if (iu_a !== prev_iu) n_tog++;
    prev_iu = iu_a;
    if (done_a) n_done++;
    if (pipe_load_a && ile_a) pipe_bad++;
    pipe_load_a = rden_a;
    if (start_a) start_a = 0;
    else if (inject_at >= 0 && rden_a && n_rd == inject_at) begin
      start_a   = 1;
      inject_at = -1;
    end
    if (resp_en) begin
      if (ack_a) ack_a = 0;
      else if (ile_a || fin_a) begin
        wcnt++;
        if (wcnt == (ile_a ? 2 : dly_rd)) begin
          ack_a = 1;
          wcnt  = 0;
        end
      end else wcnt = 0;
    end
  endtask

  task automatic run_a(input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle_a();
      if (done_a) break;
    end
    cycle_a();
  endtask

  task automatic test_reset();
    rstn = 0;
    #3;
    vectors++; if ({iu_a, fin_a, ile_a, rden_a, busy_a, done_a, err_a} !== 7'b0) begin
      miscompares++; $display("FAIL reset_ctl_a: got %b want 0000000", {iu_a, fin_a, ile_a, rden_a, busy_a, done_a, err_a});
    end
    vectors++; if ({addr_a, iter_a} !== 7'b0) begin
      miscompares++; $display("FAIL reset_cnt_a: got addr=%0d iter=%0d want 0/0", addr_a, iter_a);
    end
    vectors++; if ({iu_b, fin_b, ile_b, rden_b, busy_b, done_b, err_b, addr_b, iter_b} !== 9'b0) begin
      miscompares++; $display("FAIL reset_b: got %b want 0", {iu_b, fin_b, ile_b, rden_b, busy_b, done_b, err_b, addr_b, iter_b});
    end
    do_reset();
  endtask

  task automatic test_nominal();
    do_reset(); clear_stats();
    start_a = 1;
    run_a(200);
    vectors++; if (first_rd !== 4) begin
      miscompares++; $display("FAIL nom_latency: got %0d want 4", first_rd);
    end
    vectors++; if (n_rd !== 12) begin
      miscompares++; $display("FAIL nom_rd_cycles: got %0d want 12", n_rd);
    end
    for (int i = 0; i < 12; i++) begin
      vectors++; if (addr_log[i] !== i % 4 || iter_log[i] !== i / 4) begin
        miscompares++; $display("FAIL nom_read_%0d: got addr=%0d iter=%0d want %0d/%0d", i, addr_log[i], iter_log[i], i % 4, i / 4);
      end
    end
    vectors++; if (n_tog !== 3 || iu_a !== 1'b1) begin
      miscompares++; $display("FAIL nom_iter_update: got toggles=%0d level=%b want 3/1", n_tog, iu_a);
    end
    vectors++; if (n_done !== 1) begin
      miscompares++; $display("FAIL nom_done: got %0d pulses want 1", n_done);
    end
    vectors++; if (busy_a !== 1'b0 || iter_a !== 4'd2) begin
      miscompares++; $display("FAIL nom_idle: got busy=%b iter=%0d want 0/2", busy_a, iter_a);
    end
    vectors++; if (err_a !== 1'b0 || pipe_bad !== 0) begin
      miscompares++; $display("FAIL nom_err_pipe: got err=%b pipe_overlap=%0d want 0/0", err_a, pipe_bad);
    end
  endtask

  task automatic test_start_busy();
    int busy_seen;
    do_reset(); clear_stats();
    inject_at = 6;
    start_a = 1;
    run_a(200);
    vectors++; if (n_rd !== 12 || n_done !== 1) begin
      miscompares++; $display("FAIL busy_run: got rd=%0d done=%0d want 12/1", n_rd, n_done);
    end
    for (int i = 0; i < 12; i++) begin
      vectors++; if (iter_log[i] !== i / 4) begin
        miscompares++; $display("FAIL busy_iter_%0d: got %0d want %0d", i, iter_log[i], i / 4);
      end
    end
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cycle_a();
      if (busy_a) busy_seen++;
    end
    vectors++; if (busy_seen !== 0) begin
      miscompares++; $display("FAIL busy_no_restart: got %0d busy cycles want 0", busy_seen);
    end
  endtask

  task automatic test_delayed_ack();
    int bad;
    do_reset(); clear_stats();
    dly_rd = 1000;
    start_a = 1;
    for (int i = 0; i < 50 && !fin_a; i++) cycle_a();
    resp_en = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      cycle_a();
      if (fin_a !== 1'b1 || rden_a !== 1'b0 || iu_a !== 1'b0) bad++;
    end
    vectors++; if (bad !== 0 || n_rd !== 4) begin
      miscompares++; $display("FAIL dly_hold: got bad=%0d rd=%0d want 0/4", bad, n_rd);
    end
    ack_a = 1;
    cycle_a();
    vectors++; if (fin_a !== 1'b0 || iu_a !== 1'b0) begin
      miscompares++; $display("FAIL dly_ack_high: got fin=%b iu=%b want 0/0", fin_a, iu_a);
    end
    cycle_a(); cycle_a();
    vectors++; if (iu_a !== 1'b0 || rden_a !== 1'b0) begin
      miscompares++; $display("FAIL dly_ack_held: got iu=%b rd_en=%b want 0/0", iu_a, rden_a);
    end
    ack_a = 0;
    cycle_a();
    vectors++; if (iu_a !== 1'b0) begin
      miscompares++; $display("FAIL dly_next: got iu=%b want 0", iu_a);
    end
    cycle_a();
    vectors++; if (iu_a !== 1'b1 || rden_a !== 1'b1 || iter_a !== 4'd1 || addr_a !== 3'd0) begin
      miscompares++; $display("FAIL dly_iter1: got iu=%b rd_en=%b iter=%0d addr=%0d want 1/1/1/0", iu_a, rden_a, iter_a, addr_a);
    end
    dly_rd = 2; wcnt = 0; resp_en = 1;
    run_a(200);
    vectors++; if (n_rd !== 12 || n_done !== 1 || n_tog !== 3) begin
      miscompares++; $display("FAIL dly_finish: got rd=%0d done=%0d tog=%0d want 12/1/3", n_rd, n_done, n_tog);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    do_reset(); clear_stats();
    start_a = 1;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      cycle_a();
      if (rden_a && iter_a == 4'd1) begin
        found = 1;
        break;
      end
    end
    vectors++; if (!found || iu_a !== 1'b1) begin
      miscompares++; $display("FAIL rst_reach_iter1: got found=%0d iu=%b want 1/1", found, iu_a);
    end
    rstn = 0;
    #1;
    vectors++; if ({iu_a, fin_a, ile_a, rden_a, busy_a, done_a, addr_a, iter_a} !== 13'b0) begin
      miscompares++; $display("FAIL rst_async: got %b want 0", {iu_a, fin_a, ile_a, rden_a, busy_a, done_a, addr_a, iter_a});
    end
    @(negedge read_clk);
    rstn = 1; ack_a = 0;
    clear_stats();
    start_a = 1;
    cycle_a();
    vectors++; if (ile_a !== 1'b1 || iter_a !== 4'd0 || busy_a !== 1'b1 || rden_a !== 1'b0) begin
      miscompares++; $display("FAIL rst_restart: got ile=%b iter=%0d busy=%b rd_en=%b want 1/0/1/0", ile_a, iter_a, busy_a, rden_a);
    end
    run_a(200);
    vectors++; if (n_rd !== 12 || n_done !== 1) begin
      miscompares++; $display("FAIL rst_rerun: got rd=%0d done=%0d want 12/1", n_rd, n_done);
    end
  endtask

  task automatic test_iter1();
    int rd_cnt;
    do_reset();
    rd_cnt = 0;
    start_b = 1;
    @(negedge read_clk); start_b = 0; rd_cnt += int'(rden_b);
    vectors++; if (ile_b !== 1'b1 || busy_b !== 1'b1) begin
      miscompares++; $display("FAIL b_init: got ile=%b busy=%b want 1/1", ile_b, busy_b);
    end
    ack_b = 1;
    @(negedge read_clk); rd_cnt += int'(rden_b);
    vectors++; if (ile_b !== 1'b0 || rden_b !== 1'b0) begin
      miscompares++; $display("FAIL b_init_rel: got ile=%b rd_en=%b want 0/0", ile_b, rden_b);
    end
    ack_b = 0;
    @(negedge read_clk); rd_cnt += int'(rden_b);
    vectors++; if (rden_b !== 1'b1 || addr_b !== 1'b0) begin
      miscompares++; $display("FAIL b_read: got rd_en=%b addr=%0d want 1/0", rden_b, addr_b);
    end
    ack_b = 1;
    @(negedge read_clk); rd_cnt += int'(rden_b);
    ack_b = 0;
    vectors++; if (fin_b !== 1'b1 || rden_b !== 1'b0) begin
      miscompares++; $display("FAIL b_rd_done: got fin=%b rd_en=%b want 1/0", fin_b, rden_b);
    end
    @(negedge read_clk); rd_cnt += int'(rden_b);
    vectors++; if (fin_b !== 1'b1) begin
      miscompares++; $display("FAIL b_ack_in_read_ignored: got fin=%b want 1", fin_b);
    end
    ack_b = 1;
    @(negedge read_clk); rd_cnt += int'(rden_b);
    vectors++; if (fin_b !== 1'b0) begin
      miscompares++; $display("FAIL b_wr_rel: got fin=%b want 0", fin_b);
    end
    ack_b = 0;
    @(negedge read_clk); rd_cnt += int'(rden_b);
    vectors++; if (iu_b !== 1'b0 || done_b !== 1'b0) begin
      miscompares++; $display("FAIL b_next: got iu=%b done=%b want 0/0", iu_b, done_b);
    end
    @(negedge read_clk); rd_cnt += int'(rden_b);
    vectors++; if (done_b !== 1'b1 || iu_b !== 1'b1 || busy_b !== 1'b1) begin
      miscompares++; $display("FAIL b_done: got done=%b iu=%b busy=%b want 1/1/1", done_b, iu_b, busy_b);
    end
    @(negedge read_clk); rd_cnt += int'(rden_b);
    vectors++; if (done_b !== 1'b0 || busy_b !== 1'b0 || iu_b !== 1'b1 || rd_cnt !== 1) begin
      miscompares++; $display("FAIL b_idle: got done=%b busy=%b iu=%b rd_cycles=%0d want 0/0/1/1", done_b, busy_b, iu_b, rd_cnt);
    end
  endtask

`ifdef LUT_RD_ACK_TIMEOUT_EN
  task automatic test_timeout();
    int err_at;
    do_reset(); clear_stats();
    resp_en = 0;
    start_a = 1;
    err_at = -1;
    for (int i = 1; i <= 70; i++) begin
      cycle_a();
      if (err_a && err_at < 0) err_at = i;
    end
    vectors++; if (err_at !== 65) begin
      miscompares++; $display("FAIL to_err_time: got negedge %0d want 65", err_at);
    end
    vectors++; if (err_a !== 1'b1 || busy_a !== 1'b1 || ile_a !== 1'b0 || rden_a !== 1'b0 || fin_a !== 1'b0) begin
      miscompares++; $display("FAIL to_err_state: got err=%b busy=%b ile=%b rd_en=%b fin=%b want 1/1/0/0/0", err_a, busy_a, ile_a, rden_a, fin_a);
    end
    start_a = 1;
    cycle_a();
    vectors++; if (err_a !== 1'b0 || ile_a !== 1'b1) begin
      miscompares++; $display("FAIL to_recover: got err=%b ile=%b want 0/1", err_a, ile_a);
    end
    resp_en = 1; wcnt = 0;
    run_a(200);
    vectors++; if (n_done !== 1 || n_rd !== 12) begin
      miscompares++; $display("FAIL to_rerun: got done=%0d rd=%0d want 1/12", n_done, n_rd);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_start_busy();
    test_delayed_ack();
    test_reset_mid();
    test_iter1();
`ifdef LUT_RD_ACK_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lut_rd_iter_ctrl.md
Name: lut_rd_iter_ctrl

Overview:
- Read-side iteration sequencer for the decomposed-LUT decoding process.
- Acts as the initiator that drives the CNU/VNU write-update handshake:
  - generates the iteration-update level, the read-finish flag and the initial-load enable;
  - consumes the returned write strobe and load strobes.
- Steps the 2-input decomposed LUT reads (F_0 .. F_{dc-3}) once per iteration, up to ITER_MAX iterations, then reports completion.

Parameters:
ITER_MAX, 10, number of decoding iterations per codeword (1 .. 2^ITER_W)
ITER_W, 4, width of iteration counter
RD_CYCLES, 8, read cycles per iteration (decomposed LUT layers; 1 .. 2^RD_W)
RD_W, 3, width of read address counter
TIMEOUT_CYC, 64, ack watchdog limit (used only when macro enabled)

Ports:
read_clk  in  1  clock, all logic on rising edge; asynchronous reset rstn, active-low
rstn  in  1  asynchronous active-low reset
start_i  in  1  single-cycle request to decode one codeword; sampled only in IDLE
wr_ack_i  in  1  write strobe returned by the write-update handshake block
init_load_i  in  1  initial-load strobe from handshake block (status only)
pipe_load_i  in  1  pipeline-load strobe from handshake block (status only)
iter_update_o  out  1  iteration-update level; toggles once per completed iteration
rd_finish_o  out  1  high while read phase of current iteration is complete and awaiting write
init_load_en_o  out  1  high while in initial-load phase
rd_en_o  out  1  LUT read enable
rd_addr_o  out  RD_W  LUT layer read address
iter_cnt_o  out  ITER_W  current iteration index (0-based)
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse after final iteration
err_o  out  1  watchdog error, sticky (tied 0 when macro disabled)

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0; iter_update_o=0; counters 0.
- All outputs are registered.
- FSM states: IDLE, INIT, INIT_REL, READ, RD_DONE, WR_REL, NEXT, DONE (+ERR with macro).
- IDLE:
  - start_i=1 -> INIT next cycle; iter_cnt_o<=0, rd_addr_o<=0.
  - start_i is ignored in every other state.
- INIT: init_load_en_o=1. wr_ack_i=1 -> INIT_REL.
- INIT_REL: init_load_en_o=0. Wait wr_ack_i=0 -> READ.
- READ:
  - rd_en_o=1, rd_addr_o increments every cycle from 0.
  - After the cycle with rd_addr_o=RD_CYCLES-1 -> RD_DONE; rd_addr_o<=0.
  - Exactly RD_CYCLES rd_en_o cycles per iteration.
- RD_DONE: rd_en_o=0, rd_finish_o=1. Hold until wr_ack_i=1 -> WR_REL.
- WR_REL:
  - rd_finish_o<=0. Wait wr_ack_i=0 -> NEXT.
  - If wr_ack_i is already 0 on entry, proceed next cycle.
- NEXT (one cycle):
  - iter_update_o toggles.
  - If iter_cnt_o==ITER_MAX-1 -> DONE, else iter_cnt_o+1 -> READ.
- DONE: done_o=1 for one cycle -> IDLE. iter_cnt_o holds the final value until the next start.
- ITER_MAX=1: one READ pass, one toggle, then DONE.
- RD_CYCLES=1: READ lasts one cycle.
- wr_ack_i high in the same cycle READ ends: no effect; acknowledgement is only sampled in RD_DONE/INIT.
- init_load_i/pipe_load_i: no control effect; reserved for status/assertion checking.
- Bench assertion: pipe_load_i must not be 1 while init_load_en_o=1.
- Latency, start_i to first rd_en_o: 1 cycle to INIT, plus ack round-trip, plus 1 cycle.

Optional Feature:
- Macro LUT_RD_ACK_TIMEOUT_EN.
- Defined:
  - A wait counter runs in INIT, INIT_REL, RD_DONE and WR_REL.
  - It clears on every state change.
  - Reaching TIMEOUT_CYC -> ERR state: all strobes 0, err_o=1 sticky, busy_o=1.
  - ERR exits only on start_i=1, which clears err_o and enters INIT.
- Undefined: no counter, no ERR state, err_o tied 0; waits are unbounded.

Test Plan:
- Nominal, ITER_MAX=3, RD_CYCLES=4:
  - Stimulus: start_i pulse; bench acks wr_ack_i high 2 cycles after each INIT/RD_DONE entry, then low 1 cycle later.
  - Required: rd_en_o high 12 cycles total, addresses 0,1,2,3 per iteration; iter_update_o toggles 3 times (ends 1); one done_o pulse; busy_o low after.
- Start during busy: start_i pulsed mid-READ -> no restart; iter_cnt_o sequence unchanged.
- Delayed ack:
  - Stimulus: wr_ack_i held 0 for 20 cycles in RD_DONE.
  - Required: rd_finish_o stays 1 and rd_en_o stays 0 for all 20 cycles; iter_update_o does not toggle until ack high then low.
- Reset mid-operation: rstn low during iteration 1 READ -> all outputs 0 asynchronously; new start_i restarts at iter_cnt_o=0 with INIT.
- ITER_MAX=1, RD_CYCLES=1: exactly one rd_en_o cycle, one iter_update_o toggle, done_o pulse.
- With LUT_RD_ACK_TIMEOUT_EN and TIMEOUT_CYC=64:
  - Stimulus: wr_ack_i never asserted.
  - Required: err_o=1 at 64 cycles after INIT entry.
  - Recovery: start_i clears err_o and re-enters INIT.
